// File: rtl/attack_pkg.sv
// Shared encodings and default thresholds for the combat hit-outcome resolver.
package attack_pkg;

  // Attack type as issued by the turn controller.
  typedef enum logic [1:0] {
    TYPE_STANDBY  = 2'b00,
    TYPE_LIGHT    = 2'b01,
    TYPE_HEAVY    = 2'b10,
    TYPE_RESERVED = 2'b11
  } atk_type_t;

  // Outcome reported to the damage/HP logic.
  typedef enum logic [1:0] {
    RES_NO_HIT   = 2'b00,
    RES_CRITICAL = 2'b01,
    RES_NORMAL   = 2'b10,
    RES_MISS     = 2'b11
  } result_t;

  // Request sequencing states.
  typedef enum logic [1:0] {
    FSM_IDLE    = 2'b00,
    FSM_ROLL    = 2'b01,
    FSM_RESOLVE = 2'b10
  } fsm_t;

  // Bit positions inside the 3-bit threshold table selector.
  localparam int CFG_SEL_MISS   = 0;  // 0 crit_max, 1 miss_min
  localparam int CFG_SEL_HEAVY  = 1;  // 0 LIGHT, 1 HEAVY
  localparam int CFG_SEL_PLAYER = 2;  // 0 CPU, 1 player

  // Default thresholds at 8-bit roll resolution.
  localparam logic [7:0] DEF_CPU_LIGHT_CRIT = 8'd51;
  localparam logic [7:0] DEF_CPU_LIGHT_MISS = 8'd242;
  localparam logic [7:0] DEF_CPU_HEAVY_CRIT = 8'd76;
  localparam logic [7:0] DEF_CPU_HEAVY_MISS = 8'd206;
  localparam logic [7:0] DEF_PL_LIGHT_CRIT  = 8'd76;
  localparam logic [7:0] DEF_PL_LIGHT_MISS  = 8'd154;
  localparam logic [7:0] DEF_PL_HEAVY_CRIT  = 8'd24;
  localparam logic [7:0] DEF_PL_HEAVY_MISS  = 8'd242;

  // Default 8-bit threshold for a table selector.
  function automatic logic [7:0] default_threshold(input logic [2:0] sel);
    logic [7:0] v;
    case (sel)
      3'd0:    v = DEF_CPU_LIGHT_CRIT;
      3'd1:    v = DEF_CPU_LIGHT_MISS;
      3'd2:    v = DEF_CPU_HEAVY_CRIT;
      3'd3:    v = DEF_CPU_HEAVY_MISS;
      3'd4:    v = DEF_PL_LIGHT_CRIT;
      3'd5:    v = DEF_PL_LIGHT_MISS;
      3'd6:    v = DEF_PL_HEAVY_CRIT;
      default: v = DEF_PL_HEAVY_MISS;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci XNOR LFSR; all-ones is the lockup state, so SEED must avoid it.
module lfsr_gen #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = 8'hB8,
  parameter logic [W-1:0]   SEED = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_lfsr;

  // Shift one step every cycle out of reset; feedback is the XNOR of the tapped bits.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (i_reset) r_lfsr <= SEED;
    else         r_lfsr <= {r_lfsr[W-2:0], ~^(r_lfsr & TAPS)};
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/attack_resolver.sv
// Resolves attack requests into CRITICAL/NORMAL/MISS/NO_HIT using an LFSR roll,
// a programmable threshold table and a per-attacker miss-streak limiter.
module attack_resolver
  import attack_pkg::*;
#(
  parameter int                  LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]   TAPS       = 8'hB8,
  parameter logic [LFSR_W-1:0]   SEED       = '0,
  parameter int                  MISS_LIMIT = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic [1:0]        i_type,
  input  logic              i_isPlayer,
  input  logic              i_cfg_we,
  input  logic [2:0]        i_cfg_sel,
  input  logic [LFSR_W-1:0] i_cfg_data,
  output logic              o_busy,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [LFSR_W-1:0] o_roll
);

  // A limit of 0 still needs a 1-bit counter to keep the declarations legal.
  localparam int PITY_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

  logic [LFSR_W-1:0] w_lfsr;
  fsm_t              r_fsm;
  atk_type_t         r_type;
  logic              r_is_player;
  logic              r_busy;
  logic              r_valid;
  result_t           r_state;
  logic [LFSR_W-1:0] r_roll;
  logic [LFSR_W-1:0] r_table [8];
  logic [PITY_W-1:0] r_pity  [2];

  logic [2:0]        w_crit_idx;
  logic [2:0]        w_miss_idx;
  logic [PITY_W-1:0] w_pity_cur;
  logic [PITY_W-1:0] w_pity_next;
  result_t           w_result;

  lfsr_gen #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_value (w_lfsr)
  );

  // Threshold table: defaults on reset, single-entry writes otherwise.
  always_ff @(posedge i_clk) begin
    // NOTE: this table is reset on purpose -- its defaults are part of the game rules;
    // a plain storage RAM would be left unreset.
    if (i_reset) begin
      for (int i = 0; i < 8; i++)
        r_table[i] <= LFSR_W'(default_threshold(3'(i))) << (LFSR_W - 8);
    end else if (i_cfg_we) begin
      r_table[i_cfg_sel] <= i_cfg_data;
    end
  end

  // Classify the captured roll and work out the pity counter's next value.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_crit_idx                 = '0;
    w_crit_idx[CFG_SEL_PLAYER] = r_is_player;
    w_crit_idx[CFG_SEL_HEAVY]  = (r_type == TYPE_HEAVY);
    w_miss_idx                 = w_crit_idx;
    w_miss_idx[CFG_SEL_MISS]   = 1'b1;
    w_pity_cur                 = r_pity[r_is_player];
    w_pity_next                = w_pity_cur;
    w_result                   = RES_NO_HIT;

    if (r_type == TYPE_LIGHT || r_type == TYPE_HEAVY) begin
      if (r_roll <= r_table[w_crit_idx]) begin
        // Crit wins even if the table has miss_min <= crit_max.
        w_result    = RES_CRITICAL;
        w_pity_next = '0;
      end else if (r_roll >= r_table[w_miss_idx]) begin
        if (MISS_LIMIT != 0 && w_pity_cur == PITY_W'(MISS_LIMIT)) begin
          w_result    = RES_NORMAL;
          w_pity_next = '0;
        end else begin
          w_result    = RES_MISS;
          w_pity_next = w_pity_cur + 1'b1;
        end
      end else begin
        w_result    = RES_NORMAL;
        w_pity_next = '0;
      end
    end
  end

  // Request sequencer: capture, roll, resolve; all outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fsm       <= FSM_IDLE;
      r_type      <= TYPE_STANDBY;
      r_is_player <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_state     <= RES_NO_HIT;
      r_roll      <= '0;
      r_pity[0]   <= '0;
      r_pity[1]   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        FSM_IDLE: begin
          if (i_req) begin
            r_type      <= atk_type_t'(i_type);
            r_is_player <= i_isPlayer;
            r_busy      <= 1'b1;
            r_fsm       <= FSM_ROLL;
          end
        end
        FSM_ROLL: begin
          r_roll <= w_lfsr;
          r_fsm  <= FSM_RESOLVE;
        end
        FSM_RESOLVE: begin
          r_state             <= w_result;
          r_valid             <= 1'b1;
          r_busy              <= 1'b0;
          r_pity[r_is_player] <= w_pity_next;
          r_fsm               <= FSM_IDLE;
        end
        default: r_fsm <= FSM_IDLE;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_state = r_state;
  assign o_roll  = r_roll;

endmodule

// File: tb/tb_attack_resolver.sv
// Directed bench for attack_resolver: a transaction-level model checked every cycle,
// plus hand-computed outcomes at the threshold boundaries.
module tb_attack_resolver;

  localparam logic [7:0] SEED       = 8'h00;
  localparam int         MISS_LIMIT = 3;
  localparam int S_NO_HIT = 0, S_CRIT = 1, S_NORMAL = 2, S_MISS = 3;
  localparam logic [1:0] T_STANDBY = 2'b00, T_LIGHT = 2'b01, T_HEAVY = 2'b10, T_RSVD = 2'b11;

  logic       clk = 1'b0;
  logic       i_reset, i_req, i_isPlayer, i_cfg_we;
  logic [1:0] i_type;
  logic [2:0] i_cfg_sel;
  logic [7:0] i_cfg_data;
  logic       o_busy, o_valid;
  logic [1:0] o_state;
  logic [7:0] o_roll;

  int n_vec = 0;
  int n_err = 0;

  attack_resolver #(
    .LFSR_W(8), .TAPS(8'hB8), .SEED(SEED), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_type(i_type),
    .i_isPlayer(i_isPlayer), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
    .i_cfg_data(i_cfg_data), .o_busy(o_busy), .o_valid(o_valid),
    .o_state(o_state), .o_roll(o_roll)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ~^(v & 8'hB8)};
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] m_lfsr, m_cur, m_roll;
  logic [7:0] m_tbl [8];
  int         m_pity [2];
  bit         m_pending, m_started;
  int         m_age;
  logic [1:0] m_type;
  logic       m_pl;
  int         e_valid, e_busy, e_state, e_roll;

  function automatic logic [7:0] def_thr(input int idx);
    logic [7:0] d [8];
    d = '{8'd51, 8'd242, 8'd76, 8'd206, 8'd76, 8'd154, 8'd24, 8'd242};
    return d[idx];
  endfunction

  initial begin
    m_started = 0;
    forever begin
      @(posedge clk);
      if (i_reset) begin
        m_lfsr = SEED;
        for (int i = 0; i < 8; i++) m_tbl[i] = def_thr(i);
        m_pity[0] = 0; m_pity[1] = 0;
        m_pending = 0;
        e_valid = 0; e_busy = 0; e_state = S_NO_HIT; e_roll = 0;
        m_started = 1;
      end else begin
        m_cur  = m_lfsr;
        m_lfsr = lfsr_next(m_cur);
        e_valid = 0;
        if (m_pending) begin
          m_age++;
          if (m_age == 1) begin
            m_roll = m_cur;
            e_roll = int'(m_cur);
          end else begin
            int base, p;
            base = (m_pl ? 4 : 0) + (m_type == T_HEAVY ? 2 : 0);
            p = m_pl ? 1 : 0;
            if (m_type != T_LIGHT && m_type != T_HEAVY) e_state = S_NO_HIT;
            else if (m_roll <= m_tbl[base]) begin
              e_state = S_CRIT; m_pity[p] = 0;
            end else if (m_roll >= m_tbl[base+1]) begin
              if (MISS_LIMIT != 0 && m_pity[p] == MISS_LIMIT) begin
                e_state = S_NORMAL; m_pity[p] = 0;
              end else begin
                e_state = S_MISS; m_pity[p]++;
              end
            end else begin
              e_state = S_NORMAL; m_pity[p] = 0;
            end
            e_valid = 1; e_busy = 0; m_pending = 0;
          end
        end else if (i_req) begin
          m_pending = 1; m_age = 0; m_type = i_type; m_pl = i_isPlayer; e_busy = 1;
        end
        if (i_cfg_we) m_tbl[i_cfg_sel] = i_cfg_data;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        check("cyc_valid", int'(o_valid), e_valid);
        check("cyc_busy",  int'(o_busy),  e_busy);
        check("cyc_state", int'(o_state), e_state);
        check("cyc_roll",  int'(o_roll),  e_roll);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [7:0] data);
    i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_data = data;
    @(negedge clk);
    i_cfg_we = 1'b0;
  endtask

  // Issue one request; target >= 0 aligns the launch so the roll equals target,
  // otherwise a launch giving roll 0 is skipped. Optionally writes the table at the resolve edge.
  task automatic run_req(input logic [1:0] t, input logic p, input int target,
                         output int st, output int rl,
                         input logic wr_at_resolve = 1'b0,
                         input logic [2:0] wsel = 3'd0, input logic [7:0] wdata = 8'd0);
    int guard = 0;
    int waited;
    if (target >= 0) begin
      while (int'(lfsr_next(m_lfsr)) != target && guard < 300) begin
        @(negedge clk); guard++;
      end
    end else begin
      while (lfsr_next(m_lfsr) == 8'd0 && guard < 3) begin
        @(negedge clk); guard++;
      end
    end
    check("align_budget", int'(guard < 300), 1);
    i_req = 1'b1; i_type = t; i_isPlayer = p;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    if (wr_at_resolve) begin
      i_cfg_we = 1'b1; i_cfg_sel = wsel; i_cfg_data = wdata;
    end
    waited = 2;
    do begin
      @(negedge clk); waited++;
      i_cfg_we = 1'b0;
    end while (!o_valid && waited < 8);
    check("latency", waited, 3);
    st = int'(o_state);
    rl = int'(o_roll);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] lg [256];
  int st, rl, cnt;
  int exp_pity [5] = '{S_MISS, S_MISS, S_MISS, S_NORMAL, S_MISS};

  initial begin
    i_reset = 1'b1; i_req = 1'b0; i_type = T_STANDBY; i_isPlayer = 1'b0;
    i_cfg_we = 1'b0; i_cfg_sel = 3'd0; i_cfg_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(o_state), S_NO_HIT);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy",  int'(o_busy),  0);
    check("rst_roll",  int'(o_roll),  0);
    i_reset = 1'b0;

    // LFSR sequence properties over 256 samples.
    lg[0] = dut.w_lfsr;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      lg[i] = dut.w_lfsr;
    end
    check("lfsr_first", int'(lg[0]), int'(SEED));
    check("lfsr_wrap",  int'(lg[255]), int'(lg[0]));
    cnt = 0;
    for (int i = 1; i < 255; i++) if (lg[i] == lg[0]) cnt++;
    check("lfsr_early_repeat", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 256; i++) if (lg[i] == 8'hFF) cnt++;
    check("lfsr_all_ones", cnt, 0);

    // Latency/hold, with a second i_req held into the busy cycle.
    i_req = 1'b1; i_type = T_LIGHT; i_isPlayer = 1'b1;
    @(negedge clk);
    check("lat_busy_k1", int'(o_busy), 1);
    @(negedge clk);
    check("lat_busy_k2", int'(o_busy), 1);
    check("lat_valid_k2", int'(o_valid), 0);
    i_req = 1'b0;
    @(negedge clk);
    check("lat_valid_k3", int'(o_valid), 1);
    check("lat_busy_k3", int'(o_busy), 0);
    repeat (2) begin
      @(negedge clk);
      check("lat_no_requeue_valid", int'(o_valid), 0);
      check("lat_no_requeue_busy",  int'(o_busy),  0);
    end

    // Default player LIGHT boundaries (76 / 154).
    run_req(T_LIGHT, 1, 76, st, rl);  check("pl_light_76",  st, S_CRIT);
    run_req(T_LIGHT, 1, 77, st, rl);  check("pl_light_77",  st, S_NORMAL);
    run_req(T_LIGHT, 1, 153, st, rl); check("pl_light_153", st, S_NORMAL);
    run_req(T_LIGHT, 1, 154, st, rl); check("pl_light_154", st, S_MISS);
    check("pl_light_154_roll", rl, 154);

    // Forced crit: player HEAVY crit_max = 255.
    cfg_write(3'd6, 8'd255);
    for (int i = 0; i < 10; i++) begin
      run_req(T_HEAVY, 1, -1, st, rl);
      check($sformatf("force_crit_%0d", i), st, S_CRIT);
    end
    // Forced miss: crit_max = 0, miss_min = 1; roll 0 still crits.
    cfg_write(3'd6, 8'd0);
    cfg_write(3'd7, 8'd1);
    run_req(T_HEAVY, 1, 0, st, rl); check("force_miss_roll0", st, S_CRIT);
    run_req(T_HEAVY, 1, 1, st, rl); check("force_miss_roll1", st, S_MISS);
    for (int i = 0; i < 4; i++) run_req(T_HEAVY, 1, -1, st, rl);

    // Misconfigured table: crit wins when miss_min <= crit_max.
    cfg_write(3'd4, 8'd200);
    cfg_write(3'd5, 8'd100);
    run_req(T_LIGHT, 1, 150, st, rl); check("misconfig_crit", st, S_CRIT);

    // Pity limiter on CPU LIGHT, player requests interleaved.
    do_reset();
    cfg_write(3'd0, 8'd0);
    cfg_write(3'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      run_req(T_LIGHT, 0, -1, st, rl);
      check($sformatf("pity_%0d", i), st, exp_pity[i]);
      run_req(T_LIGHT, 1, -1, st, rl);
    end
    // STANDBY and reserved leave the CPU counter at 1.
    run_req(T_STANDBY, 0, -1, st, rl); check("standby", st, S_NO_HIT);
    run_req(T_RSVD, 0, -1, st, rl);    check("reserved", st, S_NO_HIT);
    run_req(T_LIGHT, 0, -1, st, rl);   check("pity_cont_0", st, S_MISS);
    run_req(T_LIGHT, 0, -1, st, rl);   check("pity_cont_1", st, S_MISS);
    run_req(T_LIGHT, 0, -1, st, rl);   check("pity_cont_2", st, S_NORMAL);
    run_req(T_LIGHT, 0, -1, st, rl);   check("pity_cont_3", st, S_MISS);

    // Reset during RESOLVE: no result, table and pity restored.
    cfg_write(3'd4, 8'd200);
    i_req = 1'b1; i_type = T_LIGHT; i_isPlayer = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_busy",  int'(o_busy),  0);
    i_reset = 1'b0;
    run_req(T_LIGHT, 1, 100, st, rl);
    check("midrst_default_state", st, S_NORMAL);
    check("midrst_default_roll",  rl, 100);
    cfg_write(3'd0, 8'd0);
    cfg_write(3'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      run_req(T_LIGHT, 0, -1, st, rl);
      check($sformatf("midrst_pity_%0d", i), st, (i == 3) ? S_NORMAL : S_MISS);
    end

    // Same-edge write to the entry being resolved: old crit_max (24) applies.
    run_req(T_HEAVY, 1, 100, st, rl, 1'b1, 3'd6, 8'd255);
    check("same_edge_old", st, S_NORMAL);
    run_req(T_HEAVY, 1, -1, st, rl);
    check("same_edge_new", st, S_CRIT);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/attack_resolver.md
Name: attack_resolver

Overview:
- Parametrised successor to the combat hit-outcome logic. Resolves each attack request (attack type, player/CPU) into CRITICAL / NORMAL / MISS / NO_HIT.
- Uses a free-running maximal-length LFSR, a runtime-programmable threshold table and a per-attacker miss-streak ("pity") limiter.
- Sits between the turn controller (issues requests) and the damage/HP logic (consumes results) via a req/valid handshake.

Parameters:
- LFSR_W, 8, roll width in bits. Must be >= 8.
- TAPS, 8'hB8, XNOR feedback tap mask. Default polynomial is x^8+x^6+x^5+x^4+1, period 255.
- SEED, 0, LFSR reset value. Must not be the all-ones lockup state.
- MISS_LIMIT, 3, consecutive MISSes allowed per attacker before a MISS is forced to NORMAL. 0 disables the limiter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  request strobe, accepted only while o_busy=0
- i_type  in  2  00 STANDBY, 01 LIGHT, 10 HEAVY, 11 reserved (treated as STANDBY)
- i_isPlayer  in  1  1 = player attack, 0 = CPU attack
- i_cfg_we  in  1  threshold table write enable
- i_cfg_sel  in  3  table entry: bit2 isPlayer, bit1 (0 LIGHT / 1 HEAVY), bit0 (0 crit_max / 1 miss_min)
- i_cfg_data  in  LFSR_W  threshold value to write
- o_busy  out  1  high while a request is in flight
- o_valid  out  1  one-cycle result strobe
- o_state  out  2  00 NO_HIT, 01 CRITICAL, 10 NORMAL, 11 MISS
- o_roll  out  LFSR_W  roll value used for the last result

Behaviour:
- Reset (one clock synchronous, active-high; any point, including mid-request):
  - FSM -> IDLE; any in-flight request is aborted with no o_valid.
  - o_busy=0, o_valid=0, o_state=NO_HIT, o_roll=0.
  - LFSR <= SEED; both pity counters <= 0.
  - Table loads defaults, each value << (LFSR_W-8):
    - player LIGHT 76/154, player HEAVY 24/242
    - CPU LIGHT 51/242, CPU HEAVY 76/206 (crit_max/miss_min)
- LFSR:
  - Fibonacci XNOR form; shifts every cycle out of reset, independent of FSM state.
  - Next = {lfsr[LFSR_W-2:0], ~^(lfsr & TAPS)}.
- FSM states IDLE, ROLL, RESOLVE:
  - IDLE & i_req at edge k: capture i_type and i_isPlayer -> ROLL. o_busy=1 from the cycle after edge k.
  - ROLL at edge k+1: o_roll <= lfsr -> RESOLVE.
  - RESOLVE at edge k+2: o_state <= result, o_valid <= 1 for one cycle, o_busy <= 0 -> IDLE.
  - Latency: 3 edges from acceptance to o_valid. Next acceptance is possible at edge k+3, so maximum throughput is 1 request per 3 cycles.
  - i_req while busy is ignored, not queued.
- Result for r = o_roll, using the table entry for the captured attacker and type:
  - r <= crit_max -> CRITICAL. Crit takes priority, including when the table is misconfigured (miss_min <= crit_max).
  - else r >= miss_min -> MISS.
  - else -> NORMAL.
  - STANDBY or reserved type -> NO_HIT. Full 3-cycle latency still applies; pity counter is unchanged.
- Pity limiter, one counter per attacker, width clog2(MISS_LIMIT+1):
  - If the raw result is MISS and MISS_LIMIT != 0 and the counter == MISS_LIMIT: output NORMAL, counter <= 0.
  - Otherwise a raw MISS increments the counter; CRITICAL or NORMAL clears it.
  - The other attacker's counter is never touched.
- o_state and o_roll hold their values between results.
- Config writes:
  - Accepted in any state; take effect at the next edge.
  - A write to an entry at the same edge RESOLVE reads it: the old value is used.

Decomposition:
- attack_pkg holds:
  - type encodings (STANDBY, LIGHT, HEAVY)
  - state encodings (NO_HIT, CRITICAL, NORMAL, MISS)
  - FSM state enum
  - i_cfg_sel field positions
  - 8-bit default threshold constants
- Sub-module lfsr_gen (params W, TAPS, SEED; ports i_clk, i_reset, o_value) is reused by the CPU attack-type picker.
- Table, FSM and pity logic stay in attack_resolver.

Test Plan:
- Reset values: assert i_reset 2 cycles -> o_state=00, o_valid=0, o_busy=0, o_roll=0. Release and log 256 LFSR values -> first value = SEED, period exactly 255, all-ones value never appears.
- Latency and hold: i_req with player/LIGHT at edge k -> o_busy high at k+1 and k+2; o_valid high only for the cycle after k+2; o_state holds afterwards. i_req at k+1 is ignored.
- Forced outcomes: write player HEAVY crit_max=255 -> 10 HEAVY requests all CRITICAL. Write crit_max=0, miss_min=1 -> MISS whenever o_roll != 0; check every result against o_roll.
- Pity: MISS_LIMIT=3, CPU LIGHT crit_max=0, miss_min=1; 5 requests with o_roll never 0 -> MISS, MISS, MISS, NORMAL, MISS. Interleaved player requests do not alter the CPU sequence.
- STANDBY/reserved: i_type=00 and 11 -> o_state=NO_HIT at 3-cycle latency; pity counter unchanged (next forced-MISS sequence continues from its prior count).
- Reset mid-op: i_reset during RESOLVE -> no o_valid, table back to defaults (player LIGHT with o_roll=100 -> NORMAL), pity cleared. Same-edge cfg write and resolve on one entry -> old value used.
